rv32_dmem_responder: RTL

- Data-memory responder: the memory-side end of the core's MEM-stage load/store interface.
- Accepts one load or store per handshake, sized byte, half or word (mem_size_e encoding).
- Performs byte-lane placement and load sign/zero extension, and checks alignment and address range.
- Returns a response after a fixed, configurable latency, with error and cause codes usable by the core's exception logic.

---
 rtl/rv32_dmem_if.sv | 26 ++
 rtl/rv32_dmem_responder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/rv32_dmem_if.sv
// Load/store handshake between the core's MEM stage (master) and the
// data-memory responder (slave).
interface rv32_dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [3:0]  rsp_cause;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_cause
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_cause
    );
endinterface

// File: rtl/rv32_dmem_responder.sv
// Data-memory responder: accepts one sized load/store, places byte lanes,
// checks alignment and range, and answers after a fixed latency.
module rv32_dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic      clk,
    input  logic      rst_n,
    rv32_dmem_if.slave bus
);
    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0, MEM_HALF = 2'd1, MEM_WORD = 2'd2, MEM_ILLEGAL = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    localparam int         AW             = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT       = 4'(LATENCY - 1);
    localparam logic [3:0] CAUSE_LD_MISAL = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISAL = 4'd6;
    localparam logic [3:0] CAUSE_ST_FAULT = 4'd7;

    logic [31:0] r_mem [DEPTH_WORDS];

    state_e      r_state, w_state_next;
    logic [3:0]  r_cnt;
    logic [31:0] r_pend_rdata, r_rsp_rdata;
    logic        r_pend_err, r_rsp_err;
    logic [3:0]  r_pend_cause, r_rsp_cause;

    mem_size_e   w_size;
    logic        w_req_ready, w_accept, w_enter_resp;
    logic        w_misaligned, w_out_of_range, w_err;
    logic [31:0] w_offset, w_rd_word, w_rd_shift, w_load_data, w_wlanes;
    logic [AW-1:0] w_idx;
    logic [3:0]  w_be, w_cause;

    // Held low during reset so nothing is accepted until release.
    assign w_req_ready  = (r_state == S_IDLE) && rst_n;
    assign w_accept     = bus.req_valid && w_req_ready;
    assign w_size       = mem_size_e'(bus.req_size);
    assign w_offset     = bus.req_addr - BASE_ADDR;
    assign w_idx        = w_offset[AW+1:2];
    assign w_enter_resp = (r_state != S_RESP) && (w_state_next == S_RESP);

    // Alignment/range checks, fault cause (misalignment wins) and store lane enables.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_misaligned = 1'b0;
        w_be         = 4'b0000;
        w_wlanes     = bus.req_wdata;
        case (w_size)
            MEM_BYTE: begin
                w_be     = 4'b0001 << bus.req_addr[1:0];
                w_wlanes = {4{bus.req_wdata[7:0]}};
            end
            MEM_HALF: begin
                w_misaligned = bus.req_addr[0];
                w_be         = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                w_wlanes     = {2{bus.req_wdata[15:0]}};
            end
            MEM_WORD: begin
                w_misaligned = (bus.req_addr[1:0] != 2'b00);
                w_be         = 4'b1111;
            end
            default: w_misaligned = 1'b1;
        endcase
        w_out_of_range = (bus.req_addr < BASE_ADDR) || ((w_offset >> 2) >= 32'(DEPTH_WORDS));
        w_err          = w_misaligned || w_out_of_range;
        if (w_misaligned)        w_cause = bus.req_write ? CAUSE_ST_MISAL : CAUSE_LD_MISAL;
        else if (w_out_of_range) w_cause = bus.req_write ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
        else                     w_cause = 4'd0;
    end

    // Lane-select the addressed word and extend; stores and faults return zero.
    always_comb begin
        w_rd_word   = r_mem[w_idx];
        w_rd_shift  = w_rd_word >> {bus.req_addr[1:0], 3'b000};
        w_load_data = 32'd0;
        if (!bus.req_write && !w_err) begin
            case (w_size)
                MEM_BYTE: w_load_data = bus.req_unsigned ? {24'd0, w_rd_shift[7:0]}
                                                         : {{24{w_rd_shift[7]}}, w_rd_shift[7:0]};
                MEM_HALF: w_load_data = bus.req_unsigned ? {16'd0, w_rd_shift[15:0]}
                                                         : {{16{w_rd_shift[15]}}, w_rd_shift[15:0]};
                default:  w_load_data = w_rd_word;
            endcase
        end
    end

    // Commit error-free stores at the accept edge, byte lane by byte lane.
    // NOTE: storage has no reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (w_accept && bus.req_write && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // FSM next-state: leave WAIT on the edge where the counter reaches 1.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = (LATENCY == 1) ? S_RESP : S_WAIT;
            S_WAIT:  if (r_cnt == 4'd1) w_state_next = S_RESP;
            S_RESP:  if (bus.rsp_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Latency counter: loaded on accept, counts down while waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  r_cnt <= 4'd0;
        else if (w_accept)           r_cnt <= CNT_INIT;
        else if (r_state == S_WAIT)  r_cnt <= r_cnt - 4'd1;
    end

    // Hold the accepted result while the latency elapses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_rdata <= 32'd0;
            r_pend_err   <= 1'b0;
            r_pend_cause <= 4'd0;
        end else if (w_accept) begin
            r_pend_rdata <= w_load_data;
            r_pend_err   <= w_err;
            r_pend_cause <= w_cause;
        end
    end

    // Response registers: loaded on entry to RESP, stable until the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_rsp_cause <= 4'd0;
        end else if (w_enter_resp) begin
            r_rsp_rdata <= (r_state == S_IDLE) ? w_load_data : r_pend_rdata;
            r_rsp_err   <= (r_state == S_IDLE) ? w_err       : r_pend_err;
            r_rsp_cause <= (r_state == S_IDLE) ? w_cause     : r_pend_cause;
        end else if (r_state == S_RESP && bus.rsp_ready) begin
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_rsp_cause <= 4'd0;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_cause = r_rsp_cause;
endmodule
